// File: rtl/pu_or1k_pfpu32_f2i_rnd.sv
// Back end of the pfpu32 float-to-integer conversion: mantissa alignment,
// rounding under the FPCSR mode, two's complement and saturation.
module pu_or1k_pfpu32_f2i_rnd (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        adv_i,
  input  logic [1:0]  rmode_i,
  input  logic        f2i_rdy_i,
  input  logic        f2i_sign_i,
  input  logic [23:0] f2i_int24_i,
  input  logic [4:0]  f2i_shr_i,
  input  logic [3:0]  f2i_shl_i,
  input  logic        f2i_ovf_i,
  input  logic        f2i_snan_i,
  output logic        f2i_rdy_o,
  output logic [31:0] f2i_res_o,
  output logic        f2i_inv_o,
  output logic        f2i_ix_o,
  output logic        f2i_snan_o
);

  localparam logic [1:0] RM_NEAREST = 2'd0;
  localparam logic [1:0] RM_ZERO    = 2'd1;
  localparam logic [1:0] RM_UP      = 2'd2;
  localparam logic [1:0] RM_DOWN    = 2'd3;

  function automatic logic rnd_inc(input logic [1:0] rmode, input logic sign,
                                   input logic g, input logic s, input logic lsb);
    case (rmode)
      RM_NEAREST: rnd_inc = g & (s | lsb);
      RM_ZERO:    rnd_inc = 1'b0;
      RM_UP:      rnd_inc = ~sign & (g | s);
      RM_DOWN:    rnd_inc = sign & (g | s);
      default:    rnd_inc = 1'b0;
    endcase
  endfunction

  // Negative results may reach exactly 2^31 (INT_MIN); positives stop at 2^31-1.
  function automatic logic post_ovf(input logic sign, input logic [32:0] mag33);
    if (sign) post_ovf = (mag33 > 33'h0_8000_0000);
    else      post_ovf = (mag33 > 33'h0_7FFF_FFFF);
  endfunction

  function automatic logic signed [31:0] sat_pack(input logic sign, input logic ovf,
                                                  input logic [32:0] mag33);
    if (ovf)       sat_pack = sign ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else if (sign) sat_pack = -$signed(mag33[31:0]);
    else           sat_pack = $signed(mag33[31:0]);
  endfunction

  // ---- Stage A: align mantissa, extract guard/sticky ----
  // The mantissa sits above a 32-bit field so that every right shift (0..31)
  // keeps all shifted-out bits for guard and sticky without special cases.
  logic [55:0] ext_a;
  logic [31:0] shl_mag_a;
  logic [31:0] mag_a;
  logic        g_a;
  logic        s_a;

  assign ext_a     = {f2i_int24_i, 32'd0} >> f2i_shr_i;
  assign shl_mag_a = {8'd0, f2i_int24_i} << f2i_shl_i;

  always_comb begin
    mag_a = {8'd0, ext_a[55:32]};
    g_a   = ext_a[31];
    s_a   = |ext_a[30:0];
    if (f2i_shl_i != 4'd0) begin
      mag_a = shl_mag_a;
      g_a   = 1'b0;
      s_a   = 1'b0;
    end
  end

  logic [31:0] mag_p0;
  logic        g_p0;
  logic        s_p0;
  logic        sign_p0;
  logic        ovf_p0;
  logic        snan_p0;
  logic [1:0]  rmode_p0;
  logic        vld_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_p0   <= '0;
      g_p0     <= 1'b0;
      s_p0     <= 1'b0;
      sign_p0  <= 1'b0;
      ovf_p0   <= 1'b0;
      snan_p0  <= 1'b0;
      rmode_p0 <= 2'd0;
    end else if (adv_i) begin
      mag_p0   <= mag_a;
      g_p0     <= g_a;
      s_p0     <= s_a;
      sign_p0  <= f2i_sign_i;
      ovf_p0   <= f2i_ovf_i;
      snan_p0  <= f2i_snan_i;
      rmode_p0 <= rmode_i;
    end
  end

  // ---- Stage B: round, saturate, negate ----
  logic        inc_b;
  logic [32:0] mag33_b;
  logic        ovft_b;
  logic signed [31:0] res_b;

  assign inc_b   = rnd_inc(rmode_p0, sign_p0, g_p0, s_p0, mag_p0[0]);
  assign mag33_b = {1'b0, mag_p0} + {32'd0, inc_b};
  assign ovft_b  = ovf_p0 | post_ovf(sign_p0, mag33_b);
  assign res_b   = sat_pack(sign_p0, ovft_b, mag33_b);

  logic signed [31:0] res_p1;
  logic        inv_p1;
  logic        ix_p1;
  logic        snan_p1;
  logic        vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_p1  <= '0;
      inv_p1  <= 1'b0;
      ix_p1   <= 1'b0;
      snan_p1 <= 1'b0;
    end else if (adv_i) begin
      res_p1  <= res_b;
      inv_p1  <= ovft_b;
      ix_p1   <= (g_p0 | s_p0) & ~ovft_b;
      snan_p1 <= snan_p0;
    end
  end

  // Valids: flush kills in-flight ops even on stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (flush_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (adv_i) begin
      vld_p0 <= f2i_rdy_i;
      vld_p1 <= vld_p0;
    end
  end

  assign f2i_rdy_o  = vld_p1;
  assign f2i_res_o  = res_p1;
  assign f2i_inv_o  = inv_p1;
  assign f2i_ix_o   = ix_p1;
  assign f2i_snan_o = snan_p1;

endmodule
